// File: rtl/key_cmd_queue.sv
// Key command queue: edge-detects decoder key codes and buffers presses in a FWFT FIFO.
// Optional auto-repeat of codes 5..7 is enabled by defining KEY_CMD_REPEAT_EN.
module key_cmd_queue #(
  parameter int          DEPTH         = 4,
  parameter logic [31:0] REPEAT_DELAY  = 32'd25_000_000,
  parameter logic [31:0] REPEAT_PERIOD = 32'd5_000_000
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [2:0]               key_in,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     cmd_valid,
  output logic [2:0]               cmd,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

`ifdef KEY_CMD_REPEAT_EN
  localparam logic REPEAT_EN = 1'b1;
`else
  localparam logic REPEAT_EN = 1'b0;
`endif

  logic [2:0]       mem [DEPTH];
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [2:0]       key_prev;
  logic [31:0]      rpt_cnt;
  logic             repeating;

  logic press_event;
  logic held;
  logic repeatable;
  logic rpt_fire;
  logic esc_event;
  logic push_req;
  logic do_pop;
  logic full;
  logic do_push;

  always_comb begin
    press_event = (key_in != 3'd0) && (key_in != key_prev);
    held        = (key_in != 3'd0) && (key_in == key_prev);
    repeatable  = (key_in >= 3'd5);
    rpt_fire    = REPEAT_EN && held && repeatable &&
                  (repeating ? (rpt_cnt == REPEAT_PERIOD - 32'd1)
                             : (rpt_cnt == REPEAT_DELAY - 32'd1));
    esc_event   = press_event && (key_in == 3'd1);
    push_req    = (press_event && (key_in != 3'd1)) || rpt_fire;
    full        = (count == CNT_W'(DEPTH));
    do_pop      = pop && (count != '0);
    do_push     = push_req && (!full || do_pop);
  end

  // The first repeat waits REPEAT_DELAY cycles, later ones REPEAT_PERIOD.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      key_prev  <= 3'd0;
      rpt_cnt   <= 32'd0;
      repeating <= 1'b0;
    end else begin
      key_prev <= key_in;
      if (press_event || !(held && repeatable)) begin
        rpt_cnt   <= 32'd0;
        repeating <= 1'b0;
      end else if (rpt_fire) begin
        rpt_cnt   <= 32'd0;
        repeating <= 1'b1;
      end else begin
        rpt_cnt <= rpt_cnt + 32'd1;
      end
    end
  end

  // Priority: flush, then esc (reload with a lone esc), then push/pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= 3'd0;
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (flush) begin
      rd_ptr   <= '0;
      wr_ptr   <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else if (esc_event) begin
      mem[0] <= 3'd1;
      rd_ptr <= '0;
      wr_ptr <= PTR_W'(1);
      count  <= CNT_W'(1);
    end else begin
      if (push_req && full && !do_pop) overflow <= 1'b1;
      if (do_push) begin
        mem[wr_ptr] <= key_in;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      if (do_push && !do_pop)      count <= count + CNT_W'(1);
      else if (do_pop && !do_push) count <= count - CNT_W'(1);
    end
  end

  always_comb begin
    cmd_valid = (count != '0);
    cmd       = cmd_valid ? mem[rd_ptr] : 3'd0;
  end

endmodule

// File: tb/tb_key_cmd_queue.sv
// Directed bench for key_cmd_queue with DEPTH 4; auto-repeat checks run only when KEY_CMD_REPEAT_EN is defined.
module tb_key_cmd_queue;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] key_in;
  logic       pop;
  logic       flush;
  logic       cmd_valid;
  logic [2:0] cmd;
  logic [2:0] count;
  logic       overflow;

  int compared = 0;
  int mismatched = 0;

  key_cmd_queue #(
    .DEPTH(4),
    .REPEAT_DELAY(32'd10),
    .REPEAT_PERIOD(32'd4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .key_in(key_in),
    .pop(pop),
    .flush(flush),
    .cmd_valid(cmd_valid),
    .cmd(cmd),
    .count(count),
    .overflow(overflow)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int observed, input int expected);
    compared++;
    assert (observed === expected) else begin
      mismatched++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic check_state(input string tag, input int v, input int c, input int n, input int o);
    check({tag, " valid"}, int'(cmd_valid), v);
    check({tag, " cmd"}, int'(cmd), c);
    check({tag, " count"}, int'(count), n);
    check({tag, " overflow"}, int'(overflow), o);
  endtask

  initial begin
    int pops [$];
    int hits;
    rst = 1'b0; key_in = 3'd0; pop = 1'b0; flush = 1'b0;
    #3;
    check_state("reset", 0, 0, 0, 0);
    #9 rst = 1'b1;

    // Single press then pop
    key_in = 3'd5; tick();
    check_state("press5", 1, 5, 1, 0);
    key_in = 3'd0; pop = 1'b1; tick(); pop = 1'b0;
    check_state("pop5", 0, 0, 0, 0);

    // Ordering, held key adds nothing
    key_in = 3'd3; tick();
    key_in = 3'd0; tick();
    key_in = 3'd4; tick();
    key_in = 3'd0; tick();
    key_in = 3'd6; tick(); tick(); tick();
    check_state("order", 1, 3, 3, 0);
    pop = 1'b1; tick();
    check("order pop1 cmd", int'(cmd), 4);
    tick();
    check("order pop2 cmd", int'(cmd), 6);
    tick();
    check_state("order drained", 0, 0, 0, 0);
    tick();
    check("pop on empty count", int'(count), 0);
    pop = 1'b0; key_in = 3'd0; tick();

    // Full, drop, then push with pop while full
    key_in = 3'd2; tick();
    key_in = 3'd3; tick();
    key_in = 3'd4; tick();
    key_in = 3'd5; tick();
    check_state("full", 1, 2, 4, 0);
    key_in = 3'd6; tick();
    check_state("drop", 1, 2, 4, 1);
    key_in = 3'd7; pop = 1'b1; tick();
    check_state("full push+pop", 1, 3, 4, 1);
    tick();
    check("drain cmd4", int'(cmd), 4);
    tick();
    check("drain cmd5", int'(cmd), 5);
    tick();
    check("tail cmd7", int'(cmd), 7);
    tick();
    check_state("drained", 0, 0, 0, 1);
    pop = 1'b0; key_in = 3'd0; tick();

    // Esc reload, then flush
    key_in = 3'd2; tick();
    key_in = 3'd3; tick();
    key_in = 3'd4; tick();
    check("pre-esc count", int'(count), 3);
    key_in = 3'd1; tick();
    check_state("esc", 1, 1, 1, 1);
    flush = 1'b1; tick(); flush = 1'b0;
    check_state("flush", 0, 0, 0, 0);

    // Flush suppresses the coincident press; held code afterwards is no event
    key_in = 3'd5; flush = 1'b1; tick(); flush = 1'b0;
    check("flush suppress count", int'(count), 0);
    tick();
    check("after flush held count", int'(count), 0);

    // Empty with push and pop together
    key_in = 3'd0; tick();
    key_in = 3'd6; pop = 1'b1; tick(); pop = 1'b0;
    check_state("empty push+pop", 1, 6, 1, 0);
    key_in = 3'd7; tick();
    check("second push count", int'(count), 2);

    // Asynchronous reset between edges
    rst = 1'b0; #1;
    check_state("async reset", 0, 0, 0, 0);
    #1 rst = 1'b1; key_in = 3'd0;
    tick();

`ifdef KEY_CMD_REPEAT_EN
    // Hold 5 for 20 cycles with pop every cycle
    pop = 1'b1; key_in = 3'd5;
    for (int i = 0; i < 26; i++) begin
      tick();
      if (cmd_valid) pops.push_back(i);
      if (i == 19) key_in = 3'd0;
    end
    check("repeat pops", pops.size(), 4);
    if (pops.size() == 4) begin
      check("repeat first", pops[0], 0);
      check("repeat gap1", pops[1] - pops[0], 10);
      check("repeat gap2", pops[2] - pops[1], 4);
      check("repeat gap3", pops[3] - pops[2], 4);
    end
    hits = 0;
    key_in = 3'd3;
    for (int i = 0; i < 26; i++) begin
      tick();
      if (cmd_valid) hits++;
      if (i == 19) key_in = 3'd0;
    end
    check("no repeat code3", hits, 1);
    pop = 1'b0;
`else
    // Held repeatable key must not repeat without the feature
    hits = 0;
    pop = 1'b1; key_in = 3'd5;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (cmd_valid) hits++;
    end
    check("no repeat default", hits, 1);
    pop = 1'b0; key_in = 3'd0;
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
